// File: rtl/uart_rx_deserializer_if.sv
// Receive-side result bundle of uart_rx_deserializer: recovered byte plus its status pulses.
// master drives the bundle (the receiver); slave observes it (the program collector).
interface uart_rx_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_parity_err
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input rx_parity_err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver for the boot path: recovers 8N1 bytes as one-cycle pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches.
module uart_rx_deserializer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_serial,
  output logic busy,
  uart_rx_deserializer_if.master rx
);

  localparam int DIV    = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t state;
  state_t state_next;

  logic              sync_meta;
  logic              line;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_clr;
  logic              tick;
  logic              mid_bit;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_cnt_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_next;
  logic [7:0]        shreg;
  logic [7:0]        shreg_next;
  logic [7:0]        data_q;
  logic [7:0]        data_next;
  logic              valid_q;
  logic              valid_next;
  logic              frame_q;
  logic              frame_next;
`ifdef UART_RX_PARITY_EN
  logic              par_bit;
  logic              par_bit_next;
  logic              perr_q;
  logic              perr_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      line      <= 1'b1;
    end else begin
      sync_meta <= rx_serial;
      line      <= sync_meta;
    end
  end

  // Restarting the divider at the start edge puts every sample near the bit centre.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign mid_bit = tick && (tick_cnt == ((state == S_START) ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      frame_q  <= frame_next;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_bit_next;
      perr_q   <= perr_next;
`endif
    end
  end

  // Leaving STOP at its midpoint leaves half a bit to catch an immediately following start.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick ? tick_cnt + 1'b1 : tick_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    data_next     = data_q;
    valid_next    = 1'b0;
    frame_next    = 1'b0;
    div_clr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next  = par_bit;
    perr_next     = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (!line) begin
          state_next    = S_START;
          div_clr       = 1'b1;
          tick_cnt_next = '0;
        end
      end

      S_START: begin
        if (mid_bit) begin
          tick_cnt_next = '0;
          if (line) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end
        end
      end

      S_DATA: begin
        if (mid_bit) begin
          tick_cnt_next       = '0;
          shreg_next[bit_idx] = line;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_bit) begin
          tick_cnt_next = '0;
          par_bit_next  = line;
          state_next    = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (mid_bit) begin
          tick_cnt_next = '0;
          if (!line) begin
            frame_next = 1'b1;
            state_next = S_WAIT_HIGH;
          end else begin
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bit != ^shreg) begin
              perr_next = 1'b1;
            end else begin
              valid_next = 1'b1;
              data_next  = shreg;
            end
`else
            valid_next = 1'b1;
            data_next  = shreg;
`endif
          end
        end
      end

      S_WAIT_HIGH: begin
        if (line) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy            = (state != S_IDLE);
  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = frame_q;
`ifdef UART_RX_PARITY_EN
  assign rx.rx_parity_err = perr_q;
`else
  assign rx.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are driven on rx_serial and the
// expected pulse for each is queued; a negedge monitor pops and compares every pulse.
module tb_uart_rx_deserializer;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int OVERSAMPLE  = 16;
  localparam int DIV         = 54;
  localparam int BIT_CYC     = 864;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS  = 10;
`else
  localparam int FRAME_BITS  = 9;
`endif
  // Two sync flops + START entry, then the stop-bit midpoint 9.5 bit periods past the edge.
  localparam longint LATENCY = 3 + DIV * (OVERSAMPLE * FRAME_BITS + OVERSAMPLE / 2);

  typedef enum logic [1:0] {EV_VALID, EV_FRAME, EV_PARITY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    bit         timed;
    longint     lo;
    longint     hi;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   got_exp;
  logic   clk       = 1'b0;
  logic   rst       = 1'b1;
  logic   rx_serial = 1'b1;
  logic   busy;
  longint cycle     = 0;
  int     n_checks  = 0;
  int     n_fail    = 0;
  logic   pulse_now;
  logic   pulse_prev = 1'b0;
  logic [1:0] kind_act;
  logic   in_win;

  uart_rx_deserializer_if rx_if ();

  uart_rx_deserializer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .busy     (busy),
    .rx       (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  task automatic expect_event(input ev_kind_t kind, input logic [7:0] data, input bit timed);
    exp_t e;
    e.kind  = kind;
    e.data  = data;
    e.timed = timed;
    e.lo    = cycle + LATENCY - DIV;
    e.hi    = cycle + LATENCY + DIV;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; leaves the line at the stop level, ending on a negedge.
  task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stop);
    rx_serial = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = data[i];
      repeat (BIT_CYC) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = par;
    repeat (BIT_CYC) @(negedge clk);
`else
    if (par === 1'bx) $display("[TB] parity argument unused in 8N1 build");
`endif
    rx_serial = stop;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_rx_data", rx_if.rx_data, 8'h00);
    check_output("reset_rx_valid", rx_if.rx_valid, 0);
    check_output("reset_frame_err", rx_if.rx_frame_err, 0);
    check_output("reset_parity_err", rx_if.rx_parity_err, 0);
    check_output("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Every status pulse must be one-hot, single-cycle and matched by a queued expectation.
  always @(negedge clk) begin
    pulse_now = rx_if.rx_valid | rx_if.rx_frame_err | rx_if.rx_parity_err;
    if (pulse_now && !rst) begin
      check_output("pulse_onehot",
                   32'(rx_if.rx_valid) + 32'(rx_if.rx_frame_err) + 32'(rx_if.rx_parity_err), 1);
      check_output("pulse_width", pulse_prev, 0);
      kind_act = rx_if.rx_valid ? EV_VALID : (rx_if.rx_frame_err ? EV_FRAME : EV_PARITY);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pulse: actual kind %0d data %0h, required no pulse (cycle %0d)",
                 kind_act, rx_if.rx_data, cycle);
      end else begin
        got_exp = exp_q.pop_front();
        check_output("event_kind", kind_act, got_exp.kind);
        check_output("event_data", rx_if.rx_data, got_exp.data);
        if (got_exp.timed) begin
          in_win = (cycle >= got_exp.lo) && (cycle <= got_exp.hi);
          if (!in_win) $display("[TB] pulse at cycle %0d, window %0d..%0d", cycle, got_exp.lo, got_exp.hi);
          check_output("latency_window", in_win, 1);
        end
      end
    end
    pulse_prev = pulse_now;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting uart_rx_deserializer bench");
    do_reset();

    // single 0xA5 frame with latency window
    @(negedge clk);
    expect_event(EV_VALID, 8'hA5, 1'b1);
    apply_stimulus(8'hA5, ^8'hA5, 1'b1);
    wait_drain("drain_a5", 2 * BIT_CYC);
    check_output("data_after_a5", rx_if.rx_data, 8'hA5);

    // 200-cycle glitch: start rejected at mid-bit, no pulse
    rx_serial = 1'b0;
    repeat (100) @(negedge clk);
    check_output("glitch_busy_early", busy, 1);
    repeat (100) @(negedge clk);
    rx_serial = 1'b1;
    repeat (200) @(negedge clk);
    check_output("glitch_busy_late", busy, 1);
    repeat (100) @(negedge clk);
    check_output("glitch_idle", busy, 0);
    check_output("glitch_data_kept", rx_if.rx_data, 8'hA5);

    // framing error then recovery
    do_reset();
    expect_event(EV_FRAME, 8'h00, 1'b0);
    apply_stimulus(8'h3C, ^8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check_output("break_busy", busy, 1);
    check_output("break_data_kept", rx_if.rx_data, 8'h00);
    wait_drain("drain_frame_err", 10);
    rx_serial = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    check_output("break_released", busy, 0);
    check_output("data_before_81", rx_if.rx_data, 8'h00);
    expect_event(EV_VALID, 8'h81, 1'b0);
    apply_stimulus(8'h81, ^8'h81, 1'b1);
    wait_drain("drain_81", 2 * BIT_CYC);

    // back-to-back frames with a single stop bit
    expect_event(EV_VALID, 8'h00, 1'b0);
    expect_event(EV_VALID, 8'hFF, 1'b0);
    apply_stimulus(8'h00, ^8'h00, 1'b1);
    apply_stimulus(8'hFF, ^8'hFF, 1'b1);
    wait_drain("drain_b2b", 2 * BIT_CYC);
    check_output("data_after_b2b", rx_if.rx_data, 8'hFF);

    // reset during data bit 4 of 0x77
    rx_serial = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h77 >> i) & 1;
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk);
    check_output("busy_mid_frame", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("busy_after_rst", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CYC) @(negedge clk);
    check_output("data_after_rst", rx_if.rx_data, 8'h00);
    expect_event(EV_VALID, 8'h5A, 1'b0);
    apply_stimulus(8'h5A, ^8'h5A, 1'b1);
    wait_drain("drain_5a", 2 * BIT_CYC);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity requires 1
    expect_event(EV_PARITY, 8'h5A, 1'b0);
    apply_stimulus(8'h07, 1'b0, 1'b1);
    wait_drain("drain_parity_err", 2 * BIT_CYC);
    expect_event(EV_VALID, 8'h07, 1'b0);
    apply_stimulus(8'h07, 1'b1, 1'b1);
    wait_drain("drain_parity_ok", 2 * BIT_CYC);
`endif

    repeat (BIT_CYC) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
